// File: rtl/column_renderer.sv
// rtl/column_renderer.sv - sequential block-drawing engine that walks one column of cell codes
module column_renderer #(
    parameter int NUM_CELLS  = 14,
    parameter int CODE_W     = 2,
    parameter int CELL_W     = 8,
    parameter int CELL_H     = 8,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_CELLS*CODE_W-1:0]       column_data,
    input  logic [X_W-1:0]                    x_base,
    input  logic [Y_W-1:0]                    y_base,
    input  logic [(2**CODE_W)*COLOUR_W-1:0]   palette,
    input  logic                              pix_ready,
    output logic                              pix_valid,
    output logic [X_W-1:0]                    pix_x,
    output logic [Y_W-1:0]                    pix_y,
    output logic [COLOUR_W-1:0]               pix_colour,
    output logic                              busy,
    output logic                              done
);

    localparam int DATA_W = NUM_CELLS * CODE_W;
    localparam int PAL_W  = (2**CODE_W) * COLOUR_W;
    localparam int IDX_W  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int COL_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int ROW_W  = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CELLS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELL_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

    state_t                 state_q;
    logic                   lead_q;
    logic [DATA_W-1:0]      data_q;
    logic [X_W-1:0]         xb_q;
    logic [Y_W-1:0]         yb_q;
    logic [PAL_W-1:0]       pal_q;
    logic [IDX_W-1:0]       cell_idx_q;
    logic [COL_W-1:0]       col_q;
    logic [ROW_W-1:0]       row_q;
    logic                   pix_valid_q;
    logic [X_W-1:0]         pix_x_q;
    logic [Y_W-1:0]         pix_y_q;
    logic [COLOUR_W-1:0]    colour_q;
    logic                   busy_q;
    logic                   done_q;

    logic [CODE_W-1:0]      cell_code_d;
    logic [COLOUR_W-1:0]    cell_colour_d;
    logic [Y_W-1:0]         cell_y_d;

    assign cell_code_d   = data_q[cell_idx_q*CODE_W +: CODE_W];
    assign cell_colour_d = pal_q[cell_code_d*COLOUR_W +: COLOUR_W];
    assign cell_y_d      = yb_q + Y_W'(int'(cell_idx_q) * CELL_H);

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_colour = colour_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lead_q      <= 1'b0;
            data_q      <= '0;
            xb_q        <= '0;
            yb_q        <= '0;
            pal_q       <= '0;
            cell_idx_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            colour_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q     <= column_data;
                        xb_q       <= x_base;
                        yb_q       <= y_base;
                        pal_q      <= palette;
                        cell_idx_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        lead_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    // One lead-in cycle per frame: first pixel appears two edges after the start edge
                    if (lead_q) begin
                        lead_q <= 1'b0;
                    end else if ((SKIP_EMPTY != 0) && (cell_code_d == '0)) begin
                        if (cell_idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cell_idx_q <= cell_idx_q + 1'b1;
                        end
                    end else begin
                        colour_q    <= cell_colour_d;
                        pix_x_q     <= xb_q;
                        pix_y_q     <= cell_y_d;
                        pix_valid_q <= 1'b1;
                        state_q     <= DRAW;
                    end
                end
                DRAW: begin
                    if (pix_ready) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q       <= '0;
                                pix_valid_q <= 1'b0;
                                if (cell_idx_q == IDX_LAST) begin
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    cell_idx_q <= cell_idx_q + 1'b1;
                                    state_q    <= SCAN;
                                end
                            end else begin
                                row_q   <= row_q + 1'b1;
                                pix_x_q <= xb_q;
                                pix_y_q <= pix_y_q + 1'b1;
                            end
                        end else begin
                            col_q   <= col_q + 1'b1;
                            pix_x_q <= pix_x_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_renderer.sv
// tb/tb_column_renderer.sv - scoreboard bench for column_renderer (plain and empty-skipping instances)
module tb_column_renderer;

    localparam int NUM_CELLS = 14;
    localparam int CODE_W    = 2;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 8;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int COLOUR_W  = 3;
    localparam int DATA_W    = NUM_CELLS * CODE_W;
    localparam int PAL_W     = (2**CODE_W) * COLOUR_W;
    localparam int PIX_W     = X_W + Y_W + COLOUR_W;

    typedef logic [PIX_W-1:0] pix_t;

    logic                  clk;
    logic                  reset;
    logic                  start_a [2];
    logic                  ready_a [2];
    logic [DATA_W-1:0]     column_data;
    logic [X_W-1:0]        x_base;
    logic [Y_W-1:0]        y_base;
    logic [PAL_W-1:0]      palette;
    logic                  valid_a [2];
    logic [X_W-1:0]        px_a [2];
    logic [Y_W-1:0]        py_a [2];
    logic [COLOUR_W-1:0]   pc_a [2];
    logic                  busy_a [2];
    logic                  done_a [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rmode [2];
    int   exp_done [2];
    int   done_cnt [2];
    int   xfer_cnt [2];
    logic held_v [2];
    pix_t held [2];
    pix_t exp_q0 [$];
    pix_t exp_q1 [$];

    column_renderer #(.SKIP_EMPTY(0)) u_dut (
        .clk(clk), .reset(reset), .start(start_a[0]), .column_data(column_data),
        .x_base(x_base), .y_base(y_base), .palette(palette), .pix_ready(ready_a[0]),
        .pix_valid(valid_a[0]), .pix_x(px_a[0]), .pix_y(py_a[0]), .pix_colour(pc_a[0]),
        .busy(busy_a[0]), .done(done_a[0])
    );

    column_renderer #(.SKIP_EMPTY(1)) u_skip (
        .clk(clk), .reset(reset), .start(start_a[1]), .column_data(column_data),
        .x_base(x_base), .y_base(y_base), .palette(palette), .pix_ready(ready_a[1]),
        .pix_valid(valid_a[1]), .pix_x(px_a[1]), .pix_y(py_a[1]), .pix_colour(pc_a[1]),
        .busy(busy_a[1]), .done(done_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_exp(input int d, input pix_t v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Reference: every non-skipped cell is an 8x8 row-major block, coordinates wrap by width
    task automatic model_frame(input int d, input logic [DATA_W-1:0] data, input logic [X_W-1:0] xb,
                               input logic [Y_W-1:0] yb, input logic [PAL_W-1:0] pal,
                               output int cost, output int npix);
        longint dv;
        longint pv;
        int     code;
        int     colour;
        int     x;
        int     y;
        dv = longint'(data);
        pv = longint'(pal);
        cost = 0;
        npix = 0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            code = int'((dv >> (c * CODE_W)) % (1 << CODE_W));
            if (d == 1 && code == 0) begin
                cost += 1;
            end else begin
                colour = int'((pv >> (code * COLOUR_W)) % (1 << COLOUR_W));
                for (int r = 0; r < CELL_H; r++) begin
                    for (int k = 0; k < CELL_W; k++) begin
                        x = (int'(xb) + k) % (1 << X_W);
                        y = (int'(yb) + c * CELL_H + r) % (1 << Y_W);
                        push_exp(d, {X_W'(x), Y_W'(y), COLOUR_W'(colour)});
                    end
                end
                cost += CELL_W * CELL_H + 1;
                npix += CELL_W * CELL_H;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rmode[d])
                1:       ready_a[d] = ~ready_a[d];
                2:       ready_a[d] = ($urandom % 4) != 0;
                default: ready_a[d] = 1'b1;
            endcase
        end
    end

    task automatic mon(input int d);
        pix_t cur;
        pix_t e;
        cur = {px_a[d], py_a[d], pc_a[d]};
        if (valid_a[d]) begin
            if (held_v[d]) chk($sformatf("hold[%0d]", d), cur, held[d]);
            if (ready_a[d]) begin
                xfer_cnt[d]++;
                held_v[d] = 1'b0;
                if (qsize(d) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_pixel[%0d]: got %0h expected none", d, cur);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("pixel[%0d]", d), cur, e);
                end
            end else begin
                held_v[d] = 1'b1;
                held[d]   = cur;
            end
        end else begin
            held_v[d] = 1'b0;
        end
        if (done_a[d]) begin
            done_cnt[d]++;
            if (exp_done[d] == -1) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done[%0d]: got 1 expected 0 (cycle %0d)", d, cyc);
            end else if (exp_done[d] >= 0) begin
                chk($sformatf("done_edge[%0d]", d), cyc, exp_done[d]);
            end
            exp_done[d] = -1;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic launch_frame(input int d, input logic [DATA_W-1:0] data, input logic [X_W-1:0] xb,
                                input logic [Y_W-1:0] yb, input logic [PAL_W-1:0] pal, input int mode,
                                output int npix, output int xb0, output int dc0);
        int cost;
        int e;
        rmode[d] = mode;
        @(posedge clk);
        #1;
        column_data = data;
        x_base      = xb;
        y_base      = yb;
        palette     = pal;
        start_a[d]  = 1'b1;
        e = cyc + 1;
        xb0 = xfer_cnt[d];
        dc0 = done_cnt[d];
        model_frame(d, data, xb, yb, pal, cost, npix);
        exp_done[d] = (mode == 0) ? e + 1 + cost : -2;
        @(posedge clk);
        #1;
        start_a[d] = 1'b0;
    endtask

    task automatic wait_frame(input int d, input int npix, input int xb0, input int dc0);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_a[d]) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL done_timeout[%0d]: got no done expected done within 4000 cycles", d);
        end else begin
            chk($sformatf("busy_at_done[%0d]", d), busy_a[d], 1);
            @(negedge clk);
            chk($sformatf("busy_after_done[%0d]", d), busy_a[d], 0);
            chk($sformatf("done_width[%0d]", d), done_a[d], 0);
        end
        chk($sformatf("xfer_count[%0d]", d), xfer_cnt[d] - xb0, npix);
        chk($sformatf("done_pulses[%0d]", d), done_cnt[d] - dc0, 1);
        chk($sformatf("queue_empty[%0d]", d), qsize(d), 0);
        rmode[d] = 0;
    endtask

    task automatic run_frame(input int d, input logic [DATA_W-1:0] data, input logic [X_W-1:0] xb,
                             input logic [Y_W-1:0] yb, input logic [PAL_W-1:0] pal, input int mode);
        int npix, xb0, dc0;
        launch_frame(d, data, xb, yb, pal, mode, npix, xb0, dc0);
        wait_frame(d, npix, xb0, dc0);
    endtask

    initial begin
        logic [DATA_W-1:0] ones;
        logic [PAL_W-1:0]  pal;
        int npix, xb0, dc0;

        reset = 1'b0;
        column_data = '0;
        x_base = '0;
        y_base = '0;
        palette = '0;
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0;
            ready_a[d] = 1'b1;
            rmode[d] = 0;
            exp_done[d] = -1;
            done_cnt[d] = 0;
            xfer_cnt[d] = 0;
            held_v[d] = 1'b0;
            held[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid[%0d]", d), valid_a[d], 0);
            chk($sformatf("reset_busy[%0d]", d), busy_a[d], 0);
            chk($sformatf("reset_done[%0d]", d), done_a[d], 0);
            chk($sformatf("reset_pix[%0d]", d), {px_a[d], py_a[d], pc_a[d]}, 0);
        end
        reset = 1'b1;

        ones = '0;
        for (int c = 0; c < NUM_CELLS; c++) ones = (ones << CODE_W) | DATA_W'(1);
        pal = PAL_W'($urandom);
        pal[COLOUR_W +: COLOUR_W] = 3'b010;

        run_frame(0, ones, 8'd20, 7'd0, pal, 0);
        run_frame(0, ones, 8'd20, 7'd0, pal, 1);

        pal = PAL_W'($urandom);
        pal[2*COLOUR_W +: COLOUR_W] = 3'b100;
        run_frame(1, DATA_W'(2) << (3 * CODE_W), 8'd40, 7'd0, pal, 0);

        run_frame(0, DATA_W'($urandom), 8'd252, 7'd120, PAL_W'($urandom), 0);

        launch_frame(0, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 0,
                     npix, xb0, dc0);
        repeat (100) @(posedge clk);
        #1;
        column_data = DATA_W'($urandom);
        x_base      = X_W'($urandom);
        palette     = PAL_W'($urandom);
        start_a[0]  = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        wait_frame(0, npix, xb0, dc0);

        launch_frame(0, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 0,
                     npix, xb0, dc0);
        repeat (150) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_valid", valid_a[0], 0);
        chk("abort_busy", busy_a[0], 0);
        chk("abort_done", done_a[0], 0);
        exp_q0.delete();
        exp_done[0] = -1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - dc0, 0);
        chk("abort_idle", busy_a[0], 0);
        run_frame(0, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 0);

        run_frame(1, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 0);
        for (int i = 0; i < 2; i++) begin
            run_frame(0, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 2);
            run_frame(1, DATA_W'($urandom), X_W'($urandom), Y_W'($urandom), PAL_W'($urandom), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
